exam1_a: RTL and testbench
==========================

# exam1_a

Small registered 3-operand ALU for the exam-1 datapath. Each accepted cycle it adds or subtracts two 3-bit operands, or forms the bitwise XOR or AND of three. It produces a 4-bit unsigned result plus a sign flag, so subtraction is reported as magnitude and sign. It sits between the operand-select logic and the display/compare stage and has one-cycle latency.

## Interface
Parameters:
- none (all widths fixed: operands 3 bits, result 4 bits)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands and sel are sampled on this cycle when high
- sel  input  2  operation select: 0 add, 1 subtract, 2 XOR3, 3 AND3
- a  input  3  operand A, unsigned
- b  input  3  operand B, unsigned
- c  input  3  operand C, unsigned; used only by sel 2 and 3
- d  output  4  registered result, unsigned magnitude
- neg  output  1  registered sign flag; 1 only when the subtract result is negative
- out_valid  output  1  high for one cycle after each accepted in_valid cycle

## Operation
- sel=0 (add): d = a + b, zero-extended to 4 bits; range 0..14, no overflow possible; neg=0.
- sel=1 (subtract):
  - if a >= b: d = a - b, neg=0.
  - if a < b: d = b - a, neg=1.
  - a == b gives d=0, neg=0; negative zero is never produced.
- sel=2 (XOR3): d = {1'b0, a ^ b ^ c}; neg=0.
- sel=3 (AND3): d = {1'b0, a & b & c}; neg=0.
- c is ignored for sel 0/1; a and b are used by every op.
- d[3] can be 1 only for sel=0.
- Result is computed combinationally from the sampled inputs and captured into the d/neg registers.
- When in_valid=0, d and neg hold their previous values and out_valid=0.
- Inputs containing X/Z are outside the contract; no defined output.

## Timing
- Reset: while rst_n=0, d=4'd0, neg=0 and out_valid=0 immediately, without waiting for a clock edge. The first capture is on the first rising clk edge with rst_n=1 and in_valid=1.
- Latency: inputs sampled at edge N with in_valid=1 appear on d/neg at edge N, settled before edge N+1. out_valid is high during cycle N to N+1.
- Throughput: one operation per cycle. Back-to-back in_valid cycles each produce a result, and out_valid stays high continuously.
- No backpressure; the consumer must take d/neg while out_valid=1.
- Reset asserted mid-stream: the in-flight result is discarded and outputs go to their reset values at once. After deassertion, d/neg hold 0 until the next accepted input.
- Changing sel/a/b/c while in_valid=0 has no effect on outputs.

## Test plan
- Add: (sel0, a2, b5) -> d=7, neg=0. (sel0, a7, b7) -> d=14, neg=0. out_valid pulses one cycle each.
- Subtract: (sel1, a6, b2) -> d=4, neg=0. (sel1, a4, b7) -> d=3, neg=1. (sel1, a5, b5) -> d=0, neg=0.
- XOR3 (sel2):
  - (a2, b2, c0) -> 0.
  - (a4, b1, c1) -> 4.
  - (a4, b6, c5) -> 7.
  - (a5, b4, c7) -> 6.
  - neg=0 in all cases.
- AND3 (sel3):
  - (a4, b1, c0) -> 0.
  - (a3, b1, c3) -> 1.
  - (a7, b6, c4) -> 4.
  - (a3, b2, c7) -> 2.
  - neg=0 in all cases.
- Hold: after (sel1, a4, b7) is accepted, drop in_valid and apply (sel0, a7, b7) -> d stays 3, neg stays 1, out_valid=0.
- Reset: assert rst_n=0 between clock edges after a neg=1 result -> d=0, neg=0, out_valid=0 immediately. After release, the first accepted (sel0, a1, b1) gives d=2.

Source files
------------

// File: rtl/exam1_a.sv
// exam1_a: registered 3-operand ALU (add, subtract as magnitude+sign, XOR3, AND3).
// One-cycle latency, one operation per cycle, no backpressure.
module exam1_a (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] sel,
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic [2:0] c,
  output logic [3:0] d,
  output logic       neg,
  output logic       out_valid
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  logic [3:0] d_d, d_q;
  logic       neg_d, neg_q;
  logic       valid_d, valid_q;

  // Subtraction is reported as magnitude plus sign, so a == b never yields negative zero.
  function automatic logic [3:0] sub_mag(input logic [2:0] x, input logic [2:0] y);
    logic [2:0] diff;
    if (x >= y) begin
      diff = x - y;
    end else begin
      diff = y - x;
    end
    return {1'b0, diff};
  endfunction

  // Next-state: compute result on accepted cycles, hold d/neg otherwise.
  always_comb begin
    d_d     = d_q;
    neg_d   = neg_q;
    valid_d = in_valid;
    if (in_valid) begin
      case (sel)
        OP_ADD: begin
          d_d   = {1'b0, a} + {1'b0, b};
          neg_d = 1'b0;
        end
        OP_SUB: begin
          d_d   = sub_mag(a, b);
          neg_d = (a < b);
        end
        OP_XOR: begin
          d_d   = {1'b0, a ^ b ^ c};
          neg_d = 1'b0;
        end
        OP_AND: begin
          d_d   = {1'b0, a & b & c};
          neg_d = 1'b0;
        end
        default: begin
          d_d   = 4'd0;
          neg_d = 1'b0;
        end
      endcase
    end else begin
      d_d   = d_q;
      neg_d = neg_q;
    end
  end

  // Output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= 4'd0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      neg_q   <= neg_d;
      valid_q <= valid_d;
    end
  end

  assign d         = d_q;
  assign neg       = neg_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_exam1_a.sv
// Bench for exam1_a: directed vectors with literal expectations plus an
// arithmetic reference model compared against the DUT on every falling edge.
module tb_exam1_a;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] sel;
  logic [2:0] a, b, c;
  logic [3:0] d;
  logic       neg;
  logic       out_valid;

  int n_vec;
  int n_fail;
  bit cmp_en;

  int exp_d;
  int exp_neg;
  int exp_ov;

  exam1_a dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .sel      (sel),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .neg      (neg),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_d   = 0;
      exp_neg = 0;
      exp_ov  = 0;
    end else if (in_valid) begin
      int ia, ib, ic, diff;
      ia = int'(a); ib = int'(b); ic = int'(c);
      exp_ov  = 1;
      exp_neg = 0;
      if (sel == 2'd0) begin
        exp_d = ia + ib;
      end else if (sel == 2'd1) begin
        diff    = ia - ib;
        exp_d   = (diff < 0) ? -diff : diff;
        exp_neg = (diff < 0) ? 1 : 0;
      end else if (sel == 2'd2) begin
        exp_d = ia ^ ib ^ ic;
      end else begin
        exp_d = ia & ib & ic;
      end
    end else begin
      exp_ov = 0;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_d",   int'(d),         exp_d);
      chk("model_neg", int'(neg),       exp_neg);
      chk("model_ov",  int'(out_valid), exp_ov);
    end
  end

  task automatic apply(input logic v, input logic [1:0] s, input logic [2:0] x,
                       input logic [2:0] y, input logic [2:0] z,
                       input int ed, input int en, input string name);
    @(negedge clk);
    in_valid = v; sel = s; a = x; b = y; c = z;
    @(posedge clk);
    #1;
    chk({name, "_d"},   int'(d),         ed);
    chk({name, "_neg"}, int'(neg),       en);
    chk({name, "_ov"},  int'(out_valid), v ? 1 : 0);
  endtask

  initial begin
    n_vec = 0; n_fail = 0; cmp_en = 1'b0;
    in_valid = 1'b0; sel = 2'd0; a = 3'd0; b = 3'd0; c = 3'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_d",   int'(d),         0);
    chk("rst_neg", int'(neg),       0);
    chk("rst_ov",  int'(out_valid), 0);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    apply(1'b1, 2'd0, 3'd2, 3'd5, 3'd0, 7,  0, "add_2_5");
    apply(1'b1, 2'd0, 3'd7, 3'd7, 3'd3, 14, 0, "add_7_7");
    apply(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 14, 0, "add_gap");
    apply(1'b1, 2'd1, 3'd6, 3'd2, 3'd0, 4,  0, "sub_6_2");
    apply(1'b1, 2'd1, 3'd4, 3'd7, 3'd0, 3,  1, "sub_4_7");
    apply(1'b1, 2'd1, 3'd5, 3'd5, 3'd0, 0,  0, "sub_5_5");
    apply(1'b1, 2'd2, 3'd2, 3'd2, 3'd0, 0,  0, "xor_220");
    apply(1'b1, 2'd2, 3'd4, 3'd1, 3'd1, 4,  0, "xor_411");
    apply(1'b1, 2'd2, 3'd4, 3'd6, 3'd5, 7,  0, "xor_465");
    apply(1'b1, 2'd2, 3'd5, 3'd4, 3'd7, 6,  0, "xor_547");
    apply(1'b1, 2'd3, 3'd4, 3'd1, 3'd0, 0,  0, "and_410");
    apply(1'b1, 2'd3, 3'd3, 3'd1, 3'd3, 1,  0, "and_313");
    apply(1'b1, 2'd3, 3'd7, 3'd6, 3'd4, 4,  0, "and_764");
    apply(1'b1, 2'd3, 3'd3, 3'd2, 3'd7, 2,  0, "and_327");

    // Hold: operands change while in_valid is low.
    apply(1'b1, 2'd1, 3'd4, 3'd7, 3'd0, 3,  1, "sub_hold_src");
    apply(1'b0, 2'd0, 3'd7, 3'd7, 3'd0, 3,  1, "hold_1");
    apply(1'b0, 2'd3, 3'd1, 3'd6, 3'd2, 3,  1, "hold_2");

    // Mid-cycle asynchronous reset after a negative result.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_d",   int'(d),         0);
    chk("async_rst_neg", int'(neg),       0);
    chk("async_rst_ov",  int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 2'd0, 3'd7, 3'd7, 3'd0, 0, 0, "post_rst_idle");
    apply(1'b1, 2'd0, 3'd1, 3'd1, 3'd0, 2, 0, "post_rst_add");
    apply(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 2, 0, "tail");

    // A few random vectors checked by the model only.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom_range(0, 3));
      a = 3'($urandom_range(0, 7));
      b = 3'($urandom_range(0, 7));
      c = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
